// File: rtl/psr_sequencer_if.sv
// PSR sequencer bus: request/data inputs and registered PSR outputs.
// Used with psr_sequencer; optional macro PSR_WRDELAY_EN affects WR_BUSY.
interface psr_sequencer_if #(
  parameter int CWP_WIDTH = 3
);
  localparam int W = 7 + CWP_WIDTH;

  logic         ADV;
  logic         SCC;
  logic [3:0]   Flags;
  logic         WR_REQ;
  logic [W-1:0] WR_DATA;
  logic         TRAP;
  logic         RETT;
  logic [W-1:0] Out;
  logic [3:0]   GNT;
  logic         WR_BUSY;
  logic         TRAP_ERR;

  modport master (
    output ADV, SCC, Flags, WR_REQ, WR_DATA, TRAP, RETT,
    input  Out, GNT, WR_BUSY, TRAP_ERR
  );

  modport slave (
    input  ADV, SCC, Flags, WR_REQ, WR_DATA, TRAP, RETT,
    output Out, GNT, WR_BUSY, TRAP_ERR
  );
endinterface

// File: rtl/psr_sequencer.sv
// Processor-status-register sequencer: TRAP > RETT > WRPSR > SCC per edge.
// Define PSR_WRDELAY_EN for the 3-ADV delayed WRPSR commit.
module psr_sequencer #(
  parameter int CWP_WIDTH = 3
) (
  input logic            CLK,
  input logic            RESET,
  psr_sequencer_if.slave bus
);
  localparam int W   = 7 + CWP_WIDTH;
  localparam int IS  = CWP_WIDTH + 2;
  localparam int IPS = CWP_WIDTH + 1;
  localparam int IET = CWP_WIDTH;
  localparam logic [CWP_WIDTH-1:0] ONE = 1;
  localparam logic [W-1:0] PSR_RST =
    {4'b0000, 3'b100, {CWP_WIDTH{1'b0}}};

  logic [W-1:0]         psr_q, psr_d;
  logic [3:0]           gnt_q, gnt_d;
  logic                 err_q, err_d;
  logic [CWP_WIDTH-1:0] cwp, cwp_up, cwp_dn;
  logic                 et;
  logic                 commit;
  logic [W-1:0]         cdata;

  assign cwp    = psr_q[CWP_WIDTH-1:0];
  assign cwp_up = cwp + ONE;
  assign cwp_dn = cwp - ONE;
  assign et     = psr_q[IET];

`ifdef PSR_WRDELAY_EN
  typedef enum logic {IDLE, PEND} st_t;
  st_t          st_q, st_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] wdat_q, wdat_d;

  // delayed-write FSM, count and captured data
  always_ff @(posedge CLK) begin
    if (RESET) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      wdat_q <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      wdat_q <= wdat_d;
    end
  end

  assign bus.WR_BUSY = (st_q == PEND);
`else
  logic unused_adv;
  assign unused_adv  = bus.ADV;
  assign bus.WR_BUSY = 1'b0;
`endif

  // PSR, grant pulse and sticky trap error
  always_ff @(posedge CLK) begin
    if (RESET) begin
      psr_q <= PSR_RST;
      gnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      psr_q <= psr_d;
      gnt_q <= gnt_d;
      err_q <= err_d;
    end
  end

  // source arbitration and next-state selection
  always_comb begin
    psr_d  = psr_q;
    gnt_d  = '0;
    err_d  = err_q;
    commit = 1'b0;
`ifdef PSR_WRDELAY_EN
    st_d   = st_q;
    cnt_d  = cnt_q;
    wdat_d = wdat_q;
    cdata  = wdat_q;
`else
    cdata  = bus.WR_DATA;
`endif
    if (!err_q) begin
      if (bus.TRAP) begin
        if (et) begin
          psr_d = {psr_q[W-1:W-4], 1'b1, psr_q[IS],
                   1'b0, cwp_dn};
          gnt_d = 4'b1000;
`ifdef PSR_WRDELAY_EN
          st_d  = IDLE;
          cnt_d = '0;
`endif
        end else begin
          err_d = 1'b1;
        end
      end else begin
`ifdef PSR_WRDELAY_EN
        if (st_q == IDLE) begin
          if (bus.WR_REQ) begin
            wdat_d = bus.WR_DATA;
            cnt_d  = 2'd2;
            st_d   = PEND;
          end
        end else if (bus.ADV) begin
          if (cnt_q != 2'd0) cnt_d = cnt_q - 2'd1;
          else               commit = 1'b1;
        end
`else
        commit = bus.WR_REQ;
`endif
        if (bus.RETT && !et) begin
          psr_d = {psr_q[W-1:W-4], psr_q[IPS], psr_q[IPS],
                   1'b1, cwp_up};
          gnt_d = 4'b0100;
        end else if (commit) begin
          psr_d = cdata;
          gnt_d = 4'b0010;
`ifdef PSR_WRDELAY_EN
          st_d  = IDLE;
`endif
        end else if (bus.SCC) begin
          psr_d = {bus.Flags, psr_q[W-5:0]};
          gnt_d = 4'b0001;
        end
      end
    end
  end

  assign bus.Out      = psr_q;
  assign bus.GNT      = gnt_q;
  assign bus.TRAP_ERR = err_q;
endmodule

// File: tb/tb_psr_sequencer.sv
// Directed testbench for psr_sequencer.
// Covers both builds of PSR_WRDELAY_EN.
module tb_psr_sequencer;
  localparam int CW = 3;
  localparam int W  = 7 + CW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  psr_sequencer_if #(.CWP_WIDTH(CW)) bus();

  psr_sequencer #(.CWP_WIDTH(CW)) dut (
    .CLK(clk),
    .RESET(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(
    input logic [3:0] icc, input logic s,
    input logic ps, input logic et,
    input logic [CW-1:0] cwp);
    return {icc, s, ps, et, cwp};
  endfunction

  task automatic idle_in();
    bus.ADV = 0; bus.SCC = 0; bus.Flags = 0;
    bus.WR_REQ = 0; bus.WR_DATA = '0;
    bus.TRAP = 0; bus.RETT = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wrpsr(input logic [W-1:0] d);
    bus.WR_REQ = 1; bus.WR_DATA = d; step();
    bus.WR_REQ = 0;
`ifdef PSR_WRDELAY_EN
    bus.ADV = 1; repeat (3) step(); bus.ADV = 0;
`endif
  endtask

  task automatic test_reset();
    logic [W-1:0] e;
    e = mk(4'b0000, 1, 0, 0, 0);
    bus.SCC = 1; bus.Flags = 4'hF; bus.TRAP = 1;
    bus.RETT = 1; bus.WR_REQ = 1; bus.WR_DATA = '1;
    bus.ADV = 1; rst = 1;
    step(); step();
    rst = 0; idle_in();
    vectors++;
    if (bus.Out !== e) begin miscompares++;
      $display("FAIL reset_out got=%b exp=%b", bus.Out, e); end
    vectors++;
    if (bus.GNT !== 4'b0000) begin miscompares++;
      $display("FAIL reset_gnt got=%b exp=0000", bus.GNT); end
    vectors++;
    if (bus.WR_BUSY !== 1'b0) begin miscompares++;
      $display("FAIL reset_busy got=%b exp=0", bus.WR_BUSY); end
    vectors++;
    if (bus.TRAP_ERR !== 1'b0) begin miscompares++;
      $display("FAIL reset_err got=%b exp=0", bus.TRAP_ERR); end
  endtask

  task automatic test_scc();
    logic [W-1:0] e;
    e = mk(4'b1010, 1, 0, 0, 0);
    bus.SCC = 1; bus.Flags = 4'b1010; step();
    vectors++;
    if (bus.Out !== e || bus.GNT !== 4'b0001) begin miscompares++;
      $display("FAIL scc_1010 got=%b/%b exp=%b/0001", bus.Out, bus.GNT, e); end
    bus.SCC = 0; bus.Flags = 4'b0101; step();
    vectors++;
    if (bus.Out !== e || bus.GNT !== 4'b0000) begin miscompares++;
      $display("FAIL scc_hold got=%b/%b exp=%b/0000", bus.Out, bus.GNT, e); end
    e = mk(4'b0101, 1, 0, 0, 0);
    bus.SCC = 1; step();
    vectors++;
    if (bus.Out !== e || bus.GNT !== 4'b0001) begin miscompares++;
      $display("FAIL scc_0101 got=%b/%b exp=%b/0001", bus.Out, bus.GNT, e); end
    idle_in();
  endtask

  task automatic test_wrpsr();
    logic [W-1:0] p, d;
    p = mk(4'b0101, 1, 0, 0, 0);
    d = mk(4'b0000, 1, 0, 1, 5);
`ifdef PSR_WRDELAY_EN
    bus.WR_REQ = 1; bus.WR_DATA = d; step();
    vectors++;
    if (bus.WR_BUSY !== 1'b1 || bus.Out !== p || bus.GNT !== 4'b0000) begin
      miscompares++;
      $display("FAIL wr_capture got=%b/%b/%b exp=1/%b/0000",
               bus.WR_BUSY, bus.Out, bus.GNT, p); end
    bus.WR_DATA = mk(4'b1111, 0, 1, 0, 2); bus.ADV = 1;
    for (int i = 1; i <= 2; i++) begin
      step();
      vectors++;
      if (bus.WR_BUSY !== 1'b1 || bus.Out !== p) begin miscompares++;
        $display("FAIL wr_wait%0d got=%b/%b exp=1/%b",
                 i, bus.WR_BUSY, bus.Out, p); end
    end
    step();
    vectors++;
    if (bus.Out !== d || bus.GNT !== 4'b0010 || bus.WR_BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_commit got=%b/%b/%b exp=%b/0010/0",
               bus.Out, bus.GNT, bus.WR_BUSY, d); end
    bus.WR_REQ = 0; step();
    vectors++;
    if (bus.WR_BUSY !== 1'b0 || bus.Out !== d || bus.GNT !== 4'b0000) begin
      miscompares++;
      $display("FAIL wr_discard got=%b/%b/%b exp=0/%b/0000",
               bus.WR_BUSY, bus.Out, bus.GNT, d); end
`else
    vectors++;
    if (bus.Out !== p) begin miscompares++;
      $display("FAIL wr_pre got=%b exp=%b", bus.Out, p); end
    bus.WR_REQ = 1; bus.WR_DATA = d; step();
    vectors++;
    if (bus.Out !== d || bus.GNT !== 4'b0010 || bus.WR_BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_commit got=%b/%b/%b exp=%b/0010/0",
               bus.Out, bus.GNT, bus.WR_BUSY, d); end
    bus.WR_REQ = 0; step();
    vectors++;
    if (bus.Out !== d || bus.GNT !== 4'b0000) begin miscompares++;
      $display("FAIL wr_after got=%b/%b exp=%b/0000", bus.Out, bus.GNT, d); end
`endif
    idle_in();
  endtask

  task automatic test_trap();
    logic [W-1:0] e;
    wrpsr(mk(4'b0110, 0, 0, 1, 0));
    e = mk(4'b0110, 1, 0, 0, 7);
    bus.TRAP = 1; bus.SCC = 1; bus.Flags = 4'b1111; step();
    idle_in();
    vectors++;
    if (bus.Out !== e || bus.GNT !== 4'b1000) begin miscompares++;
      $display("FAIL trap got=%b/%b exp=%b/1000", bus.Out, bus.GNT, e); end
    vectors++;
    if (bus.TRAP_ERR !== 1'b0) begin miscompares++;
      $display("FAIL trap_noerr got=%b exp=0", bus.TRAP_ERR); end
  endtask

  task automatic test_trap_err();
    logic [W-1:0] e;
    e = mk(4'b0110, 1, 0, 0, 7);
    bus.TRAP = 1; step(); bus.TRAP = 0;
    vectors++;
    if (bus.TRAP_ERR !== 1'b1 || bus.Out !== e || bus.GNT !== 4'b0000) begin
      miscompares++;
      $display("FAIL err_enter got=%b/%b/%b exp=1/%b/0000",
               bus.TRAP_ERR, bus.Out, bus.GNT, e); end
    bus.SCC = 1; bus.Flags = 4'b0001; step(); bus.SCC = 0;
    vectors++;
    if (bus.Out !== e || bus.GNT !== 4'b0000) begin miscompares++;
      $display("FAIL err_scc got=%b/%b exp=%b/0000", bus.Out, bus.GNT, e); end
    bus.RETT = 1; step(); bus.RETT = 0;
    vectors++;
    if (bus.Out !== e || bus.GNT !== 4'b0000) begin miscompares++;
      $display("FAIL err_rett got=%b/%b exp=%b/0000", bus.Out, bus.GNT, e); end
    bus.WR_REQ = 1; bus.WR_DATA = '1; bus.ADV = 1;
    repeat (4) step();
    idle_in();
    vectors++;
    if (bus.Out !== e || bus.TRAP_ERR !== 1'b1) begin miscompares++;
      $display("FAIL err_wr got=%b/%b exp=%b/1", bus.Out, bus.TRAP_ERR, e); end
    rst = 1; step(); rst = 0;
    e = mk(4'b0000, 1, 0, 0, 0);
    vectors++;
    if (bus.TRAP_ERR !== 1'b0 || bus.Out !== e) begin miscompares++;
      $display("FAIL err_clear got=%b/%b exp=0/%b", bus.TRAP_ERR, bus.Out, e); end
  endtask

  task automatic test_rett();
    logic [W-1:0] e;
    wrpsr(mk(4'b0011, 1, 0, 0, 7));
    e = mk(4'b0011, 0, 0, 1, 0);
    bus.RETT = 1; step();
    vectors++;
    if (bus.Out !== e || bus.GNT !== 4'b0100) begin miscompares++;
      $display("FAIL rett got=%b/%b exp=%b/0100", bus.Out, bus.GNT, e); end
    step(); bus.RETT = 0;
    vectors++;
    if (bus.Out !== e || bus.GNT !== 4'b0000) begin miscompares++;
      $display("FAIL rett_et1 got=%b/%b exp=%b/0000", bus.Out, bus.GNT, e); end
  endtask

`ifdef PSR_WRDELAY_EN
  task automatic test_trap_cancel();
    logic [W-1:0] e;
    wrpsr(mk(4'b0000, 0, 0, 1, 2));
    bus.WR_REQ = 1; bus.WR_DATA = mk(4'b1111, 0, 1, 1, 1); step();
    bus.WR_REQ = 0; bus.ADV = 1; step();
    bus.ADV = 0; bus.TRAP = 1; step(); bus.TRAP = 0;
    e = mk(4'b0000, 1, 0, 0, 1);
    vectors++;
    if (bus.Out !== e || bus.GNT !== 4'b1000 || bus.WR_BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL cancel_trap got=%b/%b/%b exp=%b/1000/0",
               bus.Out, bus.GNT, bus.WR_BUSY, e); end
    bus.ADV = 1; repeat (3) step(); bus.ADV = 0;
    vectors++;
    if (bus.Out !== e || bus.GNT !== 4'b0000 || bus.WR_BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL cancel_adv got=%b/%b/%b exp=%b/0000/0",
               bus.Out, bus.GNT, bus.WR_BUSY, e); end
  endtask

  task automatic test_rett_preempt();
    logic [W-1:0] x, e;
    wrpsr(mk(4'b0000, 1, 0, 0, 3));
    x = mk(4'b1100, 1, 1, 1, 4);
    bus.WR_REQ = 1; bus.WR_DATA = x; step();
    bus.WR_REQ = 0; bus.ADV = 1; step(); step();
    bus.RETT = 1; step(); bus.RETT = 0;
    e = mk(4'b0000, 0, 0, 1, 4);
    vectors++;
    if (bus.Out !== e || bus.GNT !== 4'b0100 || bus.WR_BUSY !== 1'b1) begin
      miscompares++;
      $display("FAIL preempt_rett got=%b/%b/%b exp=%b/0100/1",
               bus.Out, bus.GNT, bus.WR_BUSY, e); end
    bus.ADV = 0; step();
    vectors++;
    if (bus.Out !== e || bus.WR_BUSY !== 1'b1) begin miscompares++;
      $display("FAIL preempt_hold got=%b/%b exp=%b/1", bus.Out, bus.WR_BUSY, e); end
    bus.ADV = 1; step(); bus.ADV = 0;
    vectors++;
    if (bus.Out !== x || bus.GNT !== 4'b0010 || bus.WR_BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL preempt_commit got=%b/%b/%b exp=%b/0010/0",
               bus.Out, bus.GNT, bus.WR_BUSY, x); end
  endtask

  task automatic test_reset_midwrite();
    logic [W-1:0] e;
    bus.WR_REQ = 1; bus.WR_DATA = mk(4'b1001, 0, 1, 1, 6); step();
    bus.WR_REQ = 0; bus.ADV = 1; rst = 1; step(); rst = 0;
    repeat (3) step(); bus.ADV = 0;
    e = mk(4'b0000, 1, 0, 0, 0);
    vectors++;
    if (bus.Out !== e || bus.WR_BUSY !== 1'b0) begin miscompares++;
      $display("FAIL reset_mid got=%b/%b exp=%b/0", bus.Out, bus.WR_BUSY, e); end
  endtask
`endif

  initial begin
    idle_in();
    test_reset();
    test_scc();
    test_wrpsr();
    test_trap();
    test_trap_err();
    test_rett();
`ifdef PSR_WRDELAY_EN
    test_trap_cancel();
    test_rett_preempt();
    test_reset_midwrite();
`endif
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
